fp_cmp_pipe: RTL and testbench

Parametrised, pipelined sign-magnitude floating-point comparator. It is the successor to the 13-bit combinational greater-than compare. Operand format is {sign, exponent (unsigned), fraction (0.f, normalised, MSB=1 unless zero)}. Accepts one operand pair per cycle over a valid/ready handshake and returns gt/eq/lt flags two cycles later, with full backpressure. It sits between the operand source (FSM/register file) and any consumer that may stall.

---
 rtl/fp_cmp_pipe.sv | 108 ++++++++++
 tb/tb_fp_cmp_pipe.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cmp_pipe.sv
// fp_cmp_pipe: two-stage sign-magnitude floating-point comparator (gt/eq/lt) with valid/ready flow control.
// Build option: define FP_CMP_SIGNED_ZERO_EN to keep the sign of zero (-0 < +0); by default +0 == -0.
module fp_cmp_pipe #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  gt,
    output logic                  eq,
    output logic                  lt
);
    localparam int M_W = EXP_W + FRAC_W;

    // Handshake: a pair moves in on in_valid & in_ready and a result moves out on
    // out_valid & out_ready; a stage advances when it is empty or its successor advances.
    logic s1_v_q, s2_v_q;
    logic s1_adv, s2_adv, accept;

    assign s2_adv    = ~s2_v_q | out_ready;
    assign s1_adv    = ~s1_v_q | s2_adv;
    assign in_ready  = s1_adv & ~reset;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_v_q;

    // Stage 1 next-state: zero detection, effective signs and unsigned magnitude order.
    logic           zero_a, zero_b;
    logic [M_W-1:0] ma, mb;
    logic           es_a_d, es_b_d, mag_gt_d, mag_eq_d;

    always_comb begin
        zero_a = (a[FRAC_W-1:0] == '0);
        zero_b = (b[FRAC_W-1:0] == '0);
        ma     = zero_a ? '0 : a[M_W-1:0];
        mb     = zero_b ? '0 : b[M_W-1:0];
`ifdef FP_CMP_SIGNED_ZERO_EN
        es_a_d = a[M_W];
        es_b_d = b[M_W];
`else
        es_a_d = a[M_W] & ~zero_a;
        es_b_d = b[M_W] & ~zero_b;
`endif
        mag_gt_d = (ma > mb);
        mag_eq_d = (ma == mb);
    end

    logic es_a_q, es_b_q, mag_gt_q, mag_eq_q;

    // Stage 2 next-state: negative operands reverse the magnitude order.
    logic gt_d, eq_d, lt_d;

    always_comb begin
        gt_d = 1'b0;
        eq_d = 1'b0;
        lt_d = 1'b0;
        if (es_a_q != es_b_q) begin
            gt_d = es_b_q;
            lt_d = es_a_q;
        end else if (mag_eq_q) begin
            eq_d = 1'b1;
        end else if (mag_gt_q ^ es_a_q) begin
            gt_d = 1'b1;
        end else begin
            lt_d = 1'b1;
        end
    end

    logic gt_q, eq_q, lt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            gt_q   <= 1'b0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v_q <= accept;
                if (accept) begin
                    es_a_q   <= es_a_d;
                    es_b_q   <= es_b_d;
                    mag_gt_q <= mag_gt_d;
                    mag_eq_q <= mag_eq_d;
                end
            end
            // Flags load only with a real result, so they hold across bubbles and stalls.
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    gt_q <= gt_d;
                    eq_q <= eq_d;
                    lt_q <= lt_d;
                end
            end
        end
    end

    assign gt = gt_q;
    assign eq = eq_q;
    assign lt = lt_q;
endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Bench for fp_cmp_pipe: a 13-bit instance under directed/random traffic and a 32-bit instance
// under 10k random pairs, both scored against an ordering model built on signed integer keys.
module tb_fp_cmp_pipe;
    localparam int EW0 = 4;
    localparam int FW0 = 8;
    localparam int W0  = 1 + EW0 + FW0;
    localparam int EW1 = 8;
    localparam int FW1 = 23;
    localparam int W1  = 1 + EW1 + FW1;
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0, in_valid0, in_ready0, out_valid0, out_ready0, gt0, eq0, lt0;
    logic [W0-1:0] a0, b0;
    logic reset1, in_valid1, in_ready1, out_valid1, out_ready1, gt1, eq1, lt1;
    logic [W1-1:0] a1, b1;

    fp_cmp_pipe #(.EXP_W(EW0), .FRAC_W(FW0)) dut0 (
        .clk(clk), .reset(reset0), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
        .gt(gt0), .eq(eq0), .lt(lt0)
    );

    fp_cmp_pipe #(.EXP_W(EW1), .FRAC_W(FW1)) dut1 (
        .clk(clk), .reset(reset1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .gt(gt1), .eq(eq1), .lt(lt1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Each operand maps to a signed integer whose natural order is the required order.
    function automatic longint key(input logic [63:0] x, input int ew, input int fw);
        longint fr, ex, mag;
        bit neg, zero;
        fr   = longint'(x & ((64'd1 << fw) - 64'd1));
        ex   = longint'((x >> fw) & ((64'd1 << ew) - 64'd1));
        neg  = x[ew+fw];
        zero = (fr == 0);
        mag  = zero ? 64'sd0 : ex * (longint'(1) << fw) + fr;
`ifndef FP_CMP_SIGNED_ZERO_EN
        if (zero) neg = 1'b0;
`endif
        return neg ? -mag - 1 : mag;
    endfunction

    function automatic logic [2:0] ref_flags(input logic [63:0] x, input logic [63:0] y,
                                             input int ew, input int fw);
        longint kx, ky;
        kx = key(x, ew, fw);
        ky = key(y, ew, fw);
        if (kx > ky) return GT;
        if (kx == ky) return EQ;
        return LT;
    endfunction

    function automatic logic [63:0] rand_op(input int ew, input int fw);
        logic [63:0] fr, ex, s;
        fr = {$urandom, $urandom} & ((64'd1 << fw) - 64'd1);
        if ($urandom_range(0, 7) == 0) fr = 64'd0;
        else fr = fr | (64'd1 << (fw - 1));
        if ($urandom_range(0, 1) == 1) ex = 64'($urandom_range(0, 2));
        else ex = {32'd0, $urandom} & ((64'd1 << ew) - 64'd1);
        s = 64'($urandom_range(0, 1));
        return (s << (ew + fw)) | (ex << fw) | fr;
    endfunction

    // ---------------- scoreboards ----------------
    logic [2:0] exp_q0[$];
    int         acc_q0[$];
    logic [2:0] last0 = 3'b000;
    int         cyc0 = 0;
    bit         armed0 = 1'b0;
    logic [2:0] exp_q1[$];
    int         acc_q1[$];
    logic [2:0] last1 = 3'b000;
    int         cyc1 = 0;
    bit         armed1 = 1'b0;

    // A pair accepted in cycle c is visible at the output from cycle c+2 unless the pair ahead stalls.
    task automatic pipe_checks(input string tag, input logic rst, input logic orr, input logic ir,
                               input logic ov, input logic [2:0] fl, input int size, input int age,
                               input logic [2:0] front, input logic [2:0] last,
                               output logic ir_exp, output logic ov_exp);
        ir_exp = !rst && (size < 2 || orr);
        ov_exp = (size > 0) && (age >= 2);
        chk({tag, "_in_ready"}, ir, ir_exp);
        chk({tag, "_out_valid"}, ov, ov_exp);
        if (ov_exp) begin
            chk({tag, "_onehot"}, 64'($onehot(fl)), 64'd1);
            chk({tag, "_flags"}, fl, front);
        end else begin
            chk({tag, "_held_flags"}, fl, last);
        end
    endtask

    always @(negedge clk) begin
        logic ire, ove;
        int age;
        logic [2:0] front;
        if (armed0) begin
            age = 0;
            front = 3'b000;
            if (exp_q0.size() > 0) begin
                age = cyc0 - acc_q0[0];
                front = exp_q0[0];
            end
            pipe_checks("u0", reset0, out_ready0, in_ready0, out_valid0, {gt0, eq0, lt0},
                        exp_q0.size(), age, front, last0, ire, ove);
            if (ove && out_ready0) begin
                last0 = exp_q0.pop_front();
                void'(acc_q0.pop_front());
            end
            if (in_valid0 && ire) begin
                exp_q0.push_back(ref_flags(64'(a0), 64'(b0), EW0, FW0));
                acc_q0.push_back(cyc0);
            end
        end
        if (reset0) begin
            exp_q0.delete();
            acc_q0.delete();
            last0 = 3'b000;
            armed0 = 1'b1;
        end
        cyc0++;
    end

    always @(negedge clk) begin
        logic ire, ove;
        int age;
        logic [2:0] front;
        if (armed1) begin
            age = 0;
            front = 3'b000;
            if (exp_q1.size() > 0) begin
                age = cyc1 - acc_q1[0];
                front = exp_q1[0];
            end
            pipe_checks("u1", reset1, out_ready1, in_ready1, out_valid1, {gt1, eq1, lt1},
                        exp_q1.size(), age, front, last1, ire, ove);
            if (ove && out_ready1) begin
                last1 = exp_q1.pop_front();
                void'(acc_q1.pop_front());
            end
            if (in_valid1 && ire) begin
                exp_q1.push_back(ref_flags(64'(a1), 64'(b1), EW1, FW1));
                acc_q1.push_back(cyc1);
            end
        end
        if (reset1) begin
            exp_q1.delete();
            acc_q1.delete();
            last1 = 3'b000;
            armed1 = 1'b1;
        end
        cyc1++;
    end

    // ---------------- drivers ----------------
    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send0(input logic [W0-1:0] x, input logic [W0-1:0] y, input bit rnd);
        logic r;
        r = 1'b0;
        in_valid0 = 1'b1;
        a0 = x;
        b0 = y;
        for (int t = 0; t < 64; t++) begin
            if (rnd) out_ready0 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            r = in_ready0;
            @(posedge clk);
            #1;
            if (r) begin
                in_valid0 = 1'b0;
                return;
            end
        end
        chk("u0_accept_timeout", 64'(r), 64'd1);
        in_valid0 = 1'b0;
    endtask

    task automatic send0_lit(input logic [W0-1:0] x, input logic [W0-1:0] y,
                             input logic [2:0] exp, input string name);
        chk({"model_", name}, ref_flags(64'(x), 64'(y), EW0, FW0), exp);
        send0(x, y, 1'b0);
    endtask

    task automatic send1(input logic [W1-1:0] x, input logic [W1-1:0] y);
        logic r;
        r = 1'b0;
        in_valid1 = 1'b1;
        a1 = x;
        b1 = y;
        for (int t = 0; t < 64; t++) begin
            out_ready1 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            r = in_ready1;
            @(posedge clk);
            #1;
            if (r) begin
                in_valid1 = 1'b0;
                return;
            end
        end
        chk("u1_accept_timeout", 64'(r), 64'd1);
        in_valid1 = 1'b0;
    endtask

    task automatic idle0(input int n);
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain0();
        idle0(1);
        for (int t = 0; t < 20 && exp_q0.size() > 0; t++) idle0(1);
        chk("u0_drained", 64'(exp_q0.size()), 64'd0);
    endtask

    task automatic run0();
        logic [63:0] x, y;
        int stall_cnt;
        reset0 = 1'b1;
        in_valid0 = 1'b0;
        a0 = '0;
        b0 = '0;
        out_ready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset0 = 1'b0;
        @(negedge clk);
        chk("u0_reset_out_valid", 64'(out_valid0), 64'd0);
        chk("u0_reset_flags", 64'({gt0, eq0, lt0}), 64'd0);
        @(posedge clk);
        #1;
        // Back-to-back sign combinations.
        send0_lit(13'h0AAA, 13'h0AD7, LT, "pp");
        send0_lit(13'h1AAA, 13'h0AD7, LT, "np");
        send0_lit(13'h0AAA, 13'h1AD7, GT, "pn");
        send0_lit(13'h1AAA, 13'h1AD7, GT, "nn");
        send0_lit(13'h0DD4, 13'h1AD7, GT, "exp_pn");
        send0_lit(13'h1DD4, 13'h1AD7, LT, "exp_nn");
        send0_lit(13'h0AAA, 13'h0E86, LT, "exp_pp");
        send0_lit(13'h00AE, 13'h00AE, EQ, "eq_pos");
        send0_lit(13'h10AE, 13'h10AE, EQ, "eq_neg");
`ifdef FP_CMP_SIGNED_ZERO_EN
        send0_lit(13'h0000, 13'h1000, GT, "signed_zero");
`else
        send0_lit(13'h0000, 13'h1000, EQ, "signed_zero");
`endif
        send0_lit(13'h0A00, 13'h0000, EQ, "zero_exp");
        drain0();
        // Backpressure: out_ready low in cycles 3..7 while six pairs stream in.
        stall_cnt = 0;
        fork
            for (int i = 0; i < 6; i++) begin
                x = rand_op(EW0, FW0);
                y = rand_op(EW0, FW0);
                send0(x[W0-1:0], y[W0-1:0], 1'b0);
            end
            for (int c = 0; c < 14; c++) begin
                out_ready0 = !(c >= 3 && c <= 7);
                @(negedge clk);
                if (in_valid0 && !in_ready0) stall_cnt++;
                @(posedge clk);
                #1;
            end
        join
        chk("u0_bp_in_ready_dropped", 64'(stall_cnt > 0), 64'd1);
        drain0();
        // Reset with two pairs in flight, then latency of the first pair afterwards.
        send0(13'h0AAA, 13'h0AD7, 1'b0);
        send0(13'h1AAA, 13'h0AD7, 1'b0);
        in_valid0 = 1'b1;
        reset0 = 1'b1;
        @(negedge clk);
        chk("u0_in_ready_in_reset", 64'(in_ready0), 64'd0);
        @(posedge clk);
        #1 reset0 = 1'b0;
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("u0_flush_out_valid", 64'(out_valid0), 64'd0);
        chk("u0_flush_flags", 64'({gt0, eq0, lt0}), 64'd0);
        @(posedge clk);
        #1;
        send0_lit(13'h0DD4, 13'h1AD7, GT, "post_reset");
        @(negedge clk);
        chk("u0_post_reset_lat1", 64'(out_valid0), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("u0_post_reset_lat2", 64'({out_valid0, gt0, eq0, lt0}), 64'({1'b1, GT}));
        @(posedge clk);
        #1;
        drain0();
        // Random traffic with random gaps and random out_ready.
        for (int i = 0; i < 300; i++) begin
            x = rand_op(EW0, FW0);
            case ($urandom_range(0, 5))
                0: y = x;
                1: y = x ^ (64'd1 << (EW0 + FW0));
                default: y = rand_op(EW0, FW0);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                in_valid0 = 1'b0;
                out_ready0 = ($urandom_range(0, 1) == 1);
                @(posedge clk);
                #1;
            end
            send0(x[W0-1:0], y[W0-1:0], 1'b1);
        end
        drain0();
    endtask

    task automatic run1();
        logic [63:0] x, y;
        reset1 = 1'b1;
        in_valid1 = 1'b0;
        a1 = '0;
        b1 = '0;
        out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset1 = 1'b0;
        chk("model_wide_pp", ref_flags({32'd0, 1'b0, 8'h05, 23'h400000},
                                       {32'd0, 1'b0, 8'h01, 23'h7FFFFF}, EW1, FW1), GT);
        chk("model_wide_nn", ref_flags({32'd0, 1'b1, 8'h01, 23'h400000},
                                       {32'd0, 1'b1, 8'h05, 23'h400000}, EW1, FW1), GT);
        chk("model_wide_zero", ref_flags({32'd0, 1'b0, 8'h33, 23'h000000},
                                         {32'd0, 1'b1, 8'h01, 23'h400000}, EW1, FW1), GT);
        for (int i = 0; i < 10000; i++) begin
            x = rand_op(EW1, FW1);
            case ($urandom_range(0, 5))
                0: y = x;
                1: y = x ^ (64'd1 << (EW1 + FW1));
                default: y = rand_op(EW1, FW1);
            endcase
            if ($urandom_range(0, 7) == 0) begin
                in_valid1 = 1'b0;
                out_ready1 = ($urandom_range(0, 1) == 1);
                @(posedge clk);
                #1;
            end
            send1(x[W1-1:0], y[W1-1:0]);
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        for (int t = 0; t < 20 && exp_q1.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("u1_drained", 64'(exp_q1.size()), 64'd0);
    endtask

    initial begin
        fork
            run0();
            run1();
        join
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: finished 0, required 1 before %0d ns", 900000);
        $fatal(1);
    end
endmodule
